// File: rtl/strobe_period_checker.sv
// Locks onto a strobe that repeats every DIV clocks, flags early/late strobes,
// and regenerates a clean 1-of-DIV tick while locked.
module strobe_period_checker #(
    parameter int unsigned DIV         = 3,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned UNLOCK_ERRS = 2
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    strobe,
    input  logic                    clr_err,
    output logic                    locked,
    output logic                    tick,
    output logic                    err,
    output logic [7:0]              err_count,
    output logic [$clog2(DIV)-1:0]  phase
);

    localparam int unsigned CW = $clog2(DIV);
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MW = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [GW-1:0] good, good_d;
    logic [MW-1:0] miss, miss_d;
    logic          locked_d;
    logic          err_d;
    logic [7:0]    err_count_d;
    logic          at_end, correct, early, late;

    // Strobe classification against the expected phase.
    always_comb begin
        at_end  = (cnt == CW'(DIV - 1));
        correct = strobe & at_end;
        early   = strobe & ~at_end;
        late    = ~strobe & at_end;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state;
        cnt_d       = at_end ? '0 : cnt + CW'(1);
        good_d      = good;
        miss_d      = miss;
        err_d       = 1'b0;
        err_count_d = err_count;

        case (state)
            ST_HUNT: begin
                cnt_d = '0;
                if (strobe) begin
                    state_d = ST_VERIFY;
                    good_d  = '0;
                end
            end
            ST_VERIFY: begin
                if (correct) begin
                    good_d = good + GW'(1);
                    if (good == GW'(LOCK_CNT - 1)) begin
                        state_d = ST_LOCKED;
                        miss_d  = '0;
                    end
                end else if (early || late) begin
                    state_d = ST_HUNT;
                    good_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_LOCKED: begin
                if (correct) begin
                    miss_d = '0;
                end else if (early || late) begin
                    // Early strobe resyncs; late one flywheels on the old phase.
                    err_d  = 1'b1;
                    cnt_d  = '0;
                    miss_d = miss + MW'(1);
                    if (miss_d == MW'(UNLOCK_ERRS)) begin
                        state_d = ST_HUNT;
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
                cnt_d   = '0;
                good_d  = '0;
                miss_d  = '0;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);

        if (err_d) begin
            if (clr_err) begin
                err_count_d = 8'd1;
            end else if (err_count != 8'hFF) begin
                err_count_d = err_count + 8'd1;
            end
        end else if (clr_err) begin
            err_count_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= ST_HUNT;
            cnt       <= '0;
            good      <= '0;
            miss      <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            good      <= good_d;
            miss      <= miss_d;
            locked    <= locked_d;
            err       <= err_d;
            err_count <= err_count_d;
        end
    end

    assign tick  = locked & at_end;
    assign phase = cnt;

endmodule
